matmul_sequencer: RTL and testbench



---
 rtl/matmul_sequencer.sv | 216 +++++++++++++++++++++
 tb/tb_matmul_sequencer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_sequencer.sv
// -----------------------------------------------------------------------------
// matmul_sequencer
//
// Sequencer for the 8x8 signed matrix-multiply datapath. One run computes
// C = A * B with all three matrices stored column-major (address = row + N*col).
//
// A single issue counter walks (j,k) over 0..N*N-1, one step per cycle. A valid
// shift register follows each issue through the synchronous RAM read (stage 1,
// MAC enable) and the MAC result register (stage 2). When stage 2 carries
// k = N-1, mac_out holds a finished column. That column is latched into a
// per-lane buffer and drained to C RAM one word per cycle while the next
// column computes.
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous, active-low reset
//   start      launch a run (sampled only in IDLE)
//   busy       high while issuing (RUN) or finishing the drain (FLUSH)
//   done       one-cycle pulse after the last C word has been written
//   a_addr     N lanes x AW; lane i = i + N*k
//   b_addr     N*j + k
//   mac_en     A/B RAM outputs valid, MACs accumulate this cycle
//   mac_clear  with mac_en: MACs load the product instead of accumulating
//   mac_out    N lanes x CW signed MAC results
//   c_addr     C write address = N*j + i
//   c_data     C write data
//   c_we       C RAM write enable
// -----------------------------------------------------------------------------

// One lane of the column buffer: holds a MAC result until it is drained.
module matmul_lane_buf #(
   parameter int CW = 19
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load,
   input  logic [CW-1:0] d,
   output logic [CW-1:0] q
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)    q <= '0;
      else if (load) q <= d;
   end

endmodule

module matmul_sequencer #(
   parameter int N  = 8,
   parameter int AW = 6,
   parameter int CW = 19
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   output logic            busy,
   output logic            done,
   output logic [N*AW-1:0] a_addr,
   output logic [AW-1:0]   b_addr,
   output logic            mac_en,
   output logic            mac_clear,
   input  logic [N*CW-1:0] mac_out,
   output logic [AW-1:0]   c_addr,
   output logic [CW-1:0]   c_data,
   output logic            c_we
);

   // Row/column index width. Addresses are {column, row}, so AW = 2*KW.
   localparam int KW     = $clog2(N);
   // Stage 1: RAM data valid / MAC enable. Stage 2: MAC result visible.
   localparam int STAGES = 2;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_FLUSH,
      S_DONE
   } state_t;

   state_t state, next_state;

   // ---------------------------------------------------------------------------
   // Issue counter: issue_cnt = N*j + k, so b_addr is the counter itself.
   // ---------------------------------------------------------------------------
   logic [AW-1:0] issue_cnt;
   logic [KW-1:0] k, j;
   logic          issue_last;

   assign k          = issue_cnt[KW-1:0];
   assign j          = issue_cnt[AW-1:KW];
   assign issue_last = (issue_cnt == AW'(N*N-1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         issue_cnt <= '0;
      else if (state == S_IDLE && start)
         issue_cnt <= '0;
      else if (state == S_RUN && !issue_last)
         issue_cnt <= issue_cnt + AW'(1);
   end

   // ---------------------------------------------------------------------------
   // Valid / tag pipeline. Index 0 is the issue cycle itself.
   // ---------------------------------------------------------------------------
   logic [STAGES:0]         vld_pipe;
   logic [STAGES:1]         vld_q;
   logic [STAGES:0][KW-1:0] k_pipe, j_pipe;
   logic [STAGES:1][KW-1:0] k_q, j_q;

   assign vld_pipe = {vld_q, state == S_RUN};
   assign k_pipe   = {k_q, k};
   assign j_pipe   = {j_q, j};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vld_q <= '0;
         k_q   <= '0;
         j_q   <= '0;
      end else begin
         vld_q <= vld_pipe[STAGES-1:0];
         k_q   <= k_pipe[STAGES-1:0];
         j_q   <= j_pipe[STAGES-1:0];
      end
   end

   assign mac_en    = vld_pipe[1];
   assign mac_clear = vld_pipe[1] && (k_pipe[1] == '0);

   // Stage 2 with k = N-1: mac_out now holds the finished column j_pipe[2].
   // The next column's clear lands on this same edge, so the snapshot
   // still sees the completed sums.
   logic snap;
   assign snap = vld_pipe[2] && (k_pipe[2] == KW'(N-1));

   // ---------------------------------------------------------------------------
   // Column buffer, one instance per lane.
   // ---------------------------------------------------------------------------
   logic [N-1:0][CW-1:0] buf_q;

   for (genvar lane = 0; lane < N; lane++) begin : g_lane
      matmul_lane_buf #(.CW(CW)) u_buf (
         .clk   (clk),
         .reset (reset),
         .load  (snap),
         .d     (mac_out[lane*CW +: CW]),
         .q     (buf_q[lane])
      );
   end

   // ---------------------------------------------------------------------------
   // Drain: one C word per cycle for the N cycles after a snapshot. A new
   // snapshot always lands on the edge that ends the previous drain's final
   // write, so restarting the drain never cuts a column short.
   // ---------------------------------------------------------------------------
   logic          drain_act;
   logic [KW-1:0] drain_i;
   logic [KW-1:0] drain_col;
   logic          drain_last;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         drain_act <= 1'b0;
         drain_i   <= '0;
         drain_col <= '0;
      end else if (snap) begin
         drain_act <= 1'b1;
         drain_i   <= '0;
         drain_col <= j_pipe[2];
      end else if (drain_act) begin
         drain_i <= drain_i + KW'(1);
         if (drain_i == KW'(N-1)) drain_act <= 1'b0;
      end
   end

   assign drain_last = drain_act && (drain_i == KW'(N-1)) && (drain_col == KW'(N-1));

   assign c_we   = drain_act;
   assign c_addr = drain_act ? {drain_col, drain_i} : '0;
   assign c_data = drain_act ? buf_q[drain_i] : '0;

   // ---------------------------------------------------------------------------
   // Control FSM
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:  if (start)      next_state = S_RUN;
         S_RUN:   if (issue_last) next_state = S_FLUSH;
         S_FLUSH: if (drain_last) next_state = S_DONE;
         S_DONE:                  next_state = S_IDLE;
         default:                 next_state = S_IDLE;
      endcase
   end

   assign busy = (state == S_RUN) || (state == S_FLUSH);
   assign done = (state == S_DONE);

   // ---------------------------------------------------------------------------
   // Read addresses. Gated by busy so that everything reads zero outside a
   // run; in FLUSH the counter holds, so the last issued address persists.
   // ---------------------------------------------------------------------------
   logic [N-1:0][AW-1:0] a_lane;

   for (genvar lane = 0; lane < N; lane++) begin : g_addr
      assign a_lane[lane] = busy ? {k, KW'(lane)} : '0;
   end

   assign a_addr = a_lane;
   assign b_addr = busy ? issue_cnt : '0;

endmodule

// File: tb/tb_matmul_sequencer.sv
// -----------------------------------------------------------------------------
// tb_matmul_sequencer
//
// Directed bench for matmul_sequencer. Models the synchronous A/B RAMs and the
// MAC lanes around the sequencer, captures C writes, and compares strobes,
// addresses and the final C contents against hand-computed or golden values.
// -----------------------------------------------------------------------------
module tb_matmul_sequencer;

   localparam int N  = 8;
   localparam int AW = 6;
   localparam int CW = 19;
   localparam int LOGN = 100;

   logic            clk = 1'b0;
   logic            reset;
   logic            start;
   logic            busy, done;
   logic [N*AW-1:0] a_addr;
   logic [AW-1:0]   b_addr;
   logic            mac_en, mac_clear;
   logic [N*CW-1:0] mac_out;
   logic [AW-1:0]   c_addr;
   logic [CW-1:0]   c_data;
   logic            c_we;

   matmul_sequencer #(.N(N), .AW(AW), .CW(CW)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .busy      (busy),
      .done      (done),
      .a_addr    (a_addr),
      .b_addr    (b_addr),
      .mac_en    (mac_en),
      .mac_clear (mac_clear),
      .mac_out   (mac_out),
      .c_addr    (c_addr),
      .c_data    (c_data),
      .c_we      (c_we)
   );

   always #5 clk = ~clk;

   // ---------------- RAM + MAC environment ----------------
   logic signed [7:0]    a_mem [64];
   logic signed [7:0]    b_mem [64];
   logic signed [7:0]    a_q   [N];
   logic signed [7:0]    b_q;
   logic signed [CW-1:0] acc   [N];

   always @(posedge clk) begin
      for (int i = 0; i < N; i++) a_q[i] <= a_mem[a_addr[i*AW +: AW]];
      b_q <= b_mem[b_addr];
      if (mac_en)
         for (int i = 0; i < N; i++)
            acc[i] <= mac_clear ? CW'(int'(a_q[i]) * int'(b_q))
                                : acc[i] + CW'(int'(a_q[i]) * int'(b_q));
   end

   always_comb begin
      mac_out = '0;
      for (int i = 0; i < N; i++) mac_out[i*CW +: CW] = acc[i];
   end

   // ---------------- bookkeeping ----------------
   int checks = 0;
   int errors = 0;
   int wr_cnt;
   int wr_hits [64];
   logic [CW-1:0] c_mem [64];
   int exp_c [64];
   int abs_cyc   = 0;
   int last_done = -1;
   int done_gap  = 0;

   bit              log_busy [LOGN];
   bit              log_done [LOGN];
   bit              log_en   [LOGN];
   bit              log_clr  [LOGN];
   bit              log_we   [LOGN];
   logic [AW-1:0]   log_b    [LOGN];
   logic [N*AW-1:0] log_a    [LOGN];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   // Advance one cycle; sample C writes mid-cycle.
   task automatic tick();
      @(posedge clk);
      #1;
      abs_cyc++;
      if (c_we) begin
         wr_cnt++;
         wr_hits[c_addr]++;
         c_mem[c_addr] = c_data;
      end
      if (done) begin
         if (last_done >= 0) done_gap = abs_cyc - last_done;
         last_done = abs_cyc;
      end
   endtask

   task automatic clear_track();
      wr_cnt = 0;
      for (int a = 0; a < 64; a++) begin
         wr_hits[a] = 0;
         c_mem[a]   = '0;
      end
   endtask

   task automatic gold();
      for (int i = 0; i < N; i++)
         for (int jj = 0; jj < N; jj++) begin
            int s;
            s = 0;
            for (int kk = 0; kk < N; kk++)
               s += int'(a_mem[i + 8*kk]) * int'(b_mem[8*jj + kk]);
            exp_c[i + 8*jj] = s;
         end
   endtask

   task automatic load_random();
      for (int a = 0; a < 64; a++) begin
         a_mem[a] = 8'($urandom_range(0, 255));
         b_mem[a] = 8'($urandom_range(0, 255));
      end
      gold();
   endtask

   // Called in cycle 0 of a run; logs ncyc cycles, driving start as asked.
   task automatic run_window(input int ncyc, input int p1, input int p2, input bit hold);
      for (int t = 0; t < ncyc; t++) begin
         log_busy[t] = busy;
         log_done[t] = done;
         log_en[t]   = mac_en;
         log_clr[t]  = mac_clear;
         log_we[t]   = c_we;
         log_b[t]    = b_addr;
         log_a[t]    = a_addr;
         start = hold || (t == p1) || (t == p2);
         tick();
      end
   endtask

   task automatic check_run(input string tag, input int ncyc);
      int n_done, done_at, b_busy, b_en, b_clr, b_we, b_b, b_a;
      n_done = 0; done_at = -1;
      b_busy = 0; b_en = 0; b_clr = 0; b_we = 0; b_b = 0; b_a = 0;
      for (int t = 0; t < ncyc; t++) begin
         if (log_done[t]) begin
            n_done++;
            if (done_at < 0) done_at = t;
         end
         if (log_busy[t] != (t <= 73))                          b_busy++;
         if (log_en[t]   != (t >= 1 && t <= 64))                b_en++;
         if (log_clr[t]  != (t >= 1 && t <= 57 && (t % 8) == 1)) b_clr++;
         if (log_we[t]   != (t >= 10 && t <= 73))               b_we++;
         if (t <= 63) begin
            logic [N*AW-1:0] ea;
            if (log_b[t] !== AW'(t)) b_b++;
            for (int i = 0; i < N; i++) ea[i*AW +: AW] = AW'(i + 8*(t % 8));
            if (log_a[t] !== ea) b_a++;
         end
      end
      check({tag, "_done_count"}, n_done, 1);
      check({tag, "_done_cycle"}, done_at, 74);
      check({tag, "_busy_bad"},   b_busy, 0);
      check({tag, "_mac_en_bad"}, b_en, 0);
      check({tag, "_clear_bad"},  b_clr, 0);
      check({tag, "_c_we_bad"},   b_we, 0);
      check({tag, "_b_addr_bad"}, b_b, 0);
      check({tag, "_a_addr_bad"}, b_a, 0);
   endtask

   task automatic check_c(input string tag);
      int bad, bad_hits;
      bad = 0; bad_hits = 0;
      for (int a = 0; a < 64; a++) begin
         if (c_mem[a] !== CW'(exp_c[a])) bad++;
         if (wr_hits[a] != 1) bad_hits++;
      end
      check({tag, "_c_words_bad"}, bad, 0);
      check({tag, "_c_writes"},    wr_cnt, 64);
      check({tag, "_c_addr_hits"}, bad_hits, 0);
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_strobes"}, {busy, done, c_we, mac_en, mac_clear}, 0);
      check({tag, "_a_addr"},  a_addr, 0);
      check({tag, "_b_addr"},  b_addr, 0);
      check({tag, "_c_addr"},  c_addr, 0);
      check({tag, "_c_data"},  c_data, 0);
   endtask

   initial begin
      reset = 1'b0;
      start = 1'b0;
      for (int a = 0; a < 64; a++) begin
         a_mem[a] = '0;
         b_mem[a] = '0;
      end
      clear_track();

      // Reset state
      tick(); tick();
      check_quiet("reset");
      reset = 1'b1;
      tick(); tick();
      check_quiet("idle");

      // Identity A, B[r][c] = 8r+c-32 -> C equals B
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            a_mem[r + 8*c] = (r == c) ? 8'sd1 : 8'sd0;
            b_mem[r + 8*c] = 8'(8*r + c - 32);
            exp_c[r + 8*c] = 8*r + c - 32;
         end
      clear_track();
      start = 1'b1;
      tick();
      run_window(90, -1, -1, 1'b0);
      check_run("ident", 90);
      check_c("ident");

      // All -128, with stray start pulses at cycles 5 and 70
      for (int a = 0; a < 64; a++) begin
         a_mem[a] = -8'sd128;
         b_mem[a] = -8'sd128;
         exp_c[a] = 131072;
      end
      clear_track();
      start = 1'b1;
      tick();
      run_window(90, 5, 70, 1'b0);
      check_run("neg128", 90);
      check_c("neg128");
      check("neg128_word0", c_mem[0], 19'h20000);

      // Reset at cycle 30 (mid column 3)
      load_random();
      clear_track();
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (30) tick();
      check("pre_reset_writes", wr_cnt, 21);
      #1 reset = 1'b0;
      #1;
      check_quiet("async_reset");
      repeat (5) tick();
      check("reset_hold_writes", wr_cnt, 21);
      reset = 1'b1;
      repeat (3) tick();
      check("post_reset_busy", busy, 0);
      check("post_reset_writes", wr_cnt, 21);

      // Fresh run after reset
      clear_track();
      start = 1'b1;
      tick();
      run_window(90, -1, -1, 1'b0);
      check_run("after_rst", 90);
      check_c("after_rst");

      // 20 back-to-back random runs with start held high
      load_random();
      clear_track();
      start = 1'b1;
      tick();
      for (int r = 0; r < 20; r++) begin
         run_window(76, -1, -1, r < 19);
         check_run("b2b", 76);
         check_c("b2b");
         if (r > 0) check("b2b_done_gap", done_gap, 76);
         load_random();
         clear_track();
      end
      start = 1'b0;
      repeat (5) tick();
      check("final_idle_busy", busy, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
